// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage hazard/stall controller: register
// address width, stall FSM state encoding and bubble-count codes.
package hazard_pkg;

    localparam int ADDR_W = 5;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hz_state_t;

    localparam logic [1:0] NEED_0 = 2'd0;
    localparam logic [1:0] NEED_1 = 2'd1;
    localparam logic [1:0] NEED_2 = 2'd2;

endpackage

// File: rtl/reg_addr_match.sv
// Register address comparator: equal addresses, with register 0 never
// reported as a match.
module reg_addr_match
    import hazard_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         match
);

    logic differ;
    logic nonzero;

    always_comb begin
        differ  = |(a ^ b);
        nonzero = |a;
        match   = ~differ & nonzero;
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection and stall sequencing for the 5-stage pipeline.
// Optional stall statistics counter is built when HAZARD_STATS_EN is defined.
module hazard_stall_unit #(
    parameter int ADDR_W = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_branch_taken,
    input  logic [ADDR_W-1:0] ex_dest,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              mem_mem_read,
    input  logic              ext_freeze,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0]  stall_count,
`endif
    output logic              stall
);
    import hazard_pkg::*;

    logic      m_rs_ex, m_rt_ex, m_rs_mem, m_rt_mem;
    logic      dep_ex, dep_mem;
    logic [1:0] need;
    hz_state_t state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic      hazard_stall;

    reg_addr_match #(.W(ADDR_W)) u_rs_ex  (.a(id_rs), .b(ex_dest),  .match(m_rs_ex));
    reg_addr_match #(.W(ADDR_W)) u_rt_ex  (.a(id_rt), .b(ex_dest),  .match(m_rt_ex));
    reg_addr_match #(.W(ADDR_W)) u_rs_mem (.a(id_rs), .b(mem_dest), .match(m_rs_mem));
    reg_addr_match #(.W(ADDR_W)) u_rt_mem (.a(id_rt), .b(mem_dest), .match(m_rt_mem));

    // A branch needs its operands in ID, so it waits one cycle longer than an ALU use.
    always_comb begin
        dep_ex  = ex_reg_write && ((id_use_rs && m_rs_ex) || (id_use_rt && m_rt_ex));
        dep_mem = mem_mem_read && ((id_use_rs && m_rs_mem) || (id_use_rt && m_rt_mem));
        need    = NEED_0;
        if (id_branch && dep_ex && ex_mem_read) begin
            need = NEED_2;
        end else if ((dep_ex && ex_mem_read) || (id_branch && dep_ex) || (id_branch && dep_mem)) begin
            need = NEED_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (!ext_freeze) begin
            case (state_q)
                RUN: begin
                    if (need == NEED_2) begin
                        state_d = HOLD;
                        rem_d   = need - 2'd1;
                    end else begin
                        rem_d = 2'd0;
                    end
                end
                HOLD: begin
                    if (rem_q <= 2'd1) begin
                        state_d = RUN;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    // Reset outputs take priority, then freeze, then the hazard stall.
    always_comb begin
        hazard_stall = (state_q == HOLD) || (need != NEED_0);
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        stall        = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (ext_freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (hazard_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall       = 1'b1;
        end else begin
            ifid_flush = id_branch && id_branch_taken;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Hazard-detection and stall controller in the ID stage of the 5-stage MIPS pipeline.
- Consumes the register addresses of the ID, EX and MEM stages and performs 5-bit address equality on them.
- Produces PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
- A small FSM sequences multi-cycle stalls (branch operand waiting on a load) and holds state across external freezes.

Parameters:
- ADDR_W, 5, register address width
- CNT_W, 32, width of stall statistics counter (only with optional feature)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_branch  in  1  ID holds beq/bne (operands compared in ID)
- id_branch_taken  in  1  ID branch resolved taken
- ex_dest  in  5  EX destination register
- ex_reg_write  in  1  EX instruction writes a register
- ex_mem_read  in  1  EX instruction is a load
- mem_dest  in  5  MEM destination register
- mem_mem_read  in  1  MEM instruction is a load
- ext_freeze  in  1  global freeze (memory not ready)
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID clear (taken branch)
- idex_bubble  out  1  force ID/EX control to zero
- stall  out  1  pipeline held by a hazard
- stall_count  out  CNT_W  stalled cycles (only with optional feature)

Behaviour:
- Match rule: addr_match(a,b) = (a==b) && (a!=0). Register 0 never causes a hazard.
- dep_ex = ex_reg_write && ((id_use_rs && match(id_rs,ex_dest)) || (id_use_rt && match(id_rt,ex_dest))).
- dep_mem is defined the same way with mem_dest, qualified by mem_mem_read.
- Required bubbles `need` (2 bits), evaluated in RUN:
  - 2 if id_branch && dep_ex && ex_mem_read
  - 1 if (dep_ex && ex_mem_read) || (id_branch && dep_ex) || (id_branch && dep_mem)
  - 0 otherwise
- FSM states:
  - RUN: if need==0, no stall. If need>=1, stall asserted this cycle (Mealy). Next state is HOLD with rem=need-1 if need==2, else RUN.
  - HOLD: stall asserted unconditionally (Moore). rem decrements; when rem reaches 0 the next state is RUN, where need is re-evaluated.
- When stall=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- When no stall: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=id_branch && id_branch_taken.
- Stall and taken branch in the same cycle: the stall wins and the branch is ignored. The branch is re-resolved once operands are ready.
- ext_freeze=1 overrides everything:
  - pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0, stall=0.
  - FSM state and rem hold.
- Reset (synchronous): state=RUN, rem=0, stall_count=0.
  - Outputs while reset is high: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, stall=0.
  - Reset during HOLD abandons the stall.
- Latency: hazard to stall is 0 cycles (combinational in RUN). A back-to-back load-use then branch sequence yields exactly 2 bubbles, never 3.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: stall_count increments once per clk with stall=1 and not frozen. It saturates at all-ones and clears only on reset.
- Undefined: stall_count port is absent and no counter logic is built.

Decomposition:
- Package hazard_pkg:
  - ADDR_W
  - FSM state encoding (RUN=1'b0, HOLD=1'b1)
  - NEED_* constants (0, 1, 2)
- Sub-module reg_addr_match: 5-bit XOR/OR equality plus nonzero qualifier, with output match. Instantiated four times (rs/rt vs ex_dest/mem_dest).

Test Plan:
- Load-use: EX lw ex_dest=8, ID add rs=8 -> one cycle stall=1, pc_write=0, idex_bubble=1; next cycle stall=0.
- Register zero: EX lw ex_dest=0, ID rs=0 used -> stall=0 throughout.
- Branch after load: EX lw ex_dest=9, ID beq rt=9 -> stall=1 for exactly 2 cycles, FSM RUN->HOLD->RUN. ifid_flush=1 on the third cycle if id_branch_taken.
- Branch after ALU: EX add ex_dest=3, ID beq rs=3 taken -> 1 stall cycle, ifid_flush=0 during the stall, then ifid_flush=1.
- Freeze in HOLD: assert ext_freeze for 3 cycles mid 2-cycle stall -> outputs frozen, rem held. Remaining 1 stall cycle occurs after release. With HAZARD_STATS_EN, stall_count=2 at the end.
- Reset in HOLD: reset=1 for one cycle -> state RUN, stall=0, stall_count=0 next cycle.
